apb_arbiter: RTL and testbench

Requester-side APB controller sharing one APB bus between NUM_REQ internal requesters. Arbitrates pending requests round-robin, sequences each winner through the APB IDLE/SETUP/ACCESS phases toward an `apb_peripheral`, and returns read data and error status to the winning requester. It also pre-screens misaligned addresses and bounds peripheral stalls with a timeout.

---
 rtl/apb_pkg.sv | 23 ++
 rtl/apb_rr_select.sv | 38 +++
 rtl/apb_arbiter.sv | 143 ++++++++++++++
 tb/tb_apb_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Purpose : shared APB widths, arbiter state encoding and the alignment helper.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
// Contents: ADDR_WIDTH, DATA_WIDTH, ALIGNBITS, arb_state_t, validAlign().
package apb_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ALIGNBITS  = 2;

  typedef enum logic [1:0] {
    A_IDLE,
    A_SETUP,
    A_ACCESS,
    A_DONE
  } arb_state_t;

  // Takes only the low address bits so callers never carry unused upper bits.
  function automatic logic validAlign(input logic [ALIGNBITS-1:0] addr_lsb);
    return (addr_lsb == '0);
  endfunction

endpackage

// File: rtl/apb_rr_select.sv
// Purpose : combinational round-robin picker over a request vector.
// Latency : 0 cycles (pure combinational).
// Backpressure : none; the caller decides when to act on the winner.
// Ports: req_i (pending requests), last_grant_i (previous winner index),
//        win_oh_o / win_idx_o (winner as one-hot and index), any_req_o.
module apb_rr_select #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDXW-1:0]    last_grant_i,
  output logic [NUM_REQ-1:0] win_oh_o,
  output logic [IDXW-1:0]    win_idx_o,
  output logic               any_req_o
);

  logic [IDXW-1:0] cand;
  logic            found;

  // Scan starting one past the previous winner and wrap; the first hit wins.
  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDXW'((int'(last_grant_i) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        win_idx_o       = cand;
        win_oh_o[cand]  = 1'b1;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/apb_arbiter.sv
// Purpose : shares one APB master port between NUM_REQ requesters, round-robin.
// Latency : req->psel 1 cycle; zero-wait transfer 4 cycles; misaligned 2 cycles.
// Backpressure : pready stalls ACCESS; after TIMEOUT stalled cycles the transfer errors out.
// Ports: pclk/preset; req, req_write, req_addr, req_wdata in; gnt, done, rdata, err out;
//        APB master side psel, penable, pwrite, paddr, pwdata out, pready, pslverr, prdata in.
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                               pclk,
  input  logic                               preset,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                 gnt,
  output logic [NUM_REQ-1:0]                 done,
  output logic [DATA_WIDTH-1:0]              rdata,
  output logic                               err,
  output logic                               psel,
  output logic                               penable,
  output logic                               pwrite,
  output logic [ADDR_WIDTH-1:0]              paddr,
  output logic [DATA_WIDTH-1:0]              pwdata,
  input  logic                               pready,
  input  logic                               pslverr,
  input  logic [DATA_WIDTH-1:0]              prdata
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int CW   = $clog2(TIMEOUT + 1);

  arb_state_t          state_q;
  logic [IDXW-1:0]     last_q;
  logic [CW-1:0]       cnt_q;
  logic                psel_q, penable_q, pwrite_q, err_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q, rdata_q;
  logic [NUM_REQ-1:0]  gnt_q, done_q;

  logic [NUM_REQ-1:0]  win_oh;
  logic [IDXW-1:0]     win_idx;
  logic                any_req;
  logic [ALIGNBITS-1:0] win_lsb;

  apb_rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_sel (
    .req_i        (req),
    .last_grant_i (last_q),
    .win_oh_o     (win_oh),
    .win_idx_o    (win_idx),
    .any_req_o    (any_req)
  );

  assign win_lsb = req_addr[win_idx][ALIGNBITS-1:0];

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= A_IDLE;
      last_q    <= IDXW'(NUM_REQ - 1);  // requester 0 wins first after reset
      cnt_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        A_IDLE: begin
          if (any_req) begin
            // Command is captured here and stays on the bus until the next grant.
            pwrite_q <= req_write[win_idx];
            paddr_q  <= req_addr[win_idx];
            pwdata_q <= req_wdata[win_idx];
            last_q   <= win_idx;
            gnt_q    <= win_oh;
            if (validAlign(win_lsb)) begin
              psel_q  <= 1'b1;
              state_q <= A_SETUP;
            end else begin
              // Misaligned: complete with error without touching the bus.
              done_q  <= win_oh;
              err_q   <= 1'b1;
              rdata_q <= '0;
              state_q <= A_DONE;
            end
          end
        end
        A_SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= A_ACCESS;
        end
        A_ACCESS: begin
          if (pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= gnt_q;
            err_q     <= pslverr;
            rdata_q   <= pwrite_q ? '0 : prdata;
            state_q   <= A_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            // This stalled cycle is the TIMEOUT-th one: give up with an error.
            if (cnt_q == CW'(TIMEOUT - 1)) begin
              psel_q    <= 1'b0;
              penable_q <= 1'b0;
              done_q    <= gnt_q;
              err_q     <= 1'b1;
              rdata_q   <= '0;
              state_q   <= A_DONE;
            end
          end
        end
        A_DONE: begin
          done_q  <= '0;
          gnt_q   <= '0;
          state_q <= A_IDLE;
        end
        default: state_q <= A_IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign err     = err_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Purpose : self-checking bench for apb_arbiter with a behavioural APB peripheral.
// Latency : n/a.
// Backpressure : peripheral wait states are programmable per transfer (per_wait, -1 = never ready).
module tb_apb_arbiter;
  import apb_pkg::*;

  localparam int NR = 4;
  localparam int TO = 16;
  localparam int IW = $clog2(NR);

  logic                          pclk;
  logic                          preset;
  logic [NR-1:0]                 req, req_write, gnt, done;
  logic [NR-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NR-1:0][DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0]         rdata, pwdata, prdata;
  logic [ADDR_WIDTH-1:0]         paddr;
  logic                          err, psel, penable, pwrite, pready, pslverr;

  int checks;
  int errors;
  int per_wait;
  logic per_err;
  logic [DATA_WIDTH-1:0] per_rdata;
  int acc_cnt;

  apb_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Peripheral: ready after per_wait stalled ACCESS cycles (never if negative).
  assign pready  = psel && penable && (per_wait >= 0) && (acc_cnt == per_wait);
  assign pslverr = per_err;
  assign prdata  = per_rdata;
  always @(posedge pclk) acc_cnt <= (psel && penable) ? acc_cnt + 1 : 0;

  // Advance one cycle, sample after the edge; owners drop req while done is shown.
  task automatic tick();
    @(posedge pclk);
    #1;
    req = req & ~done;
  endtask

  task automatic apply_reset();
    preset = 1'b1;
    tick();
    tick();
    preset = 1'b0;
  endtask

  function automatic int oh2idx(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++)
      if (((v >> i) & NR'(1)) != '0) r = (r == -1) ? i : -2;
    return r;
  endfunction

  // Rotating priority: first pending index after 'last', wrapping.
  function automatic int rr_pick(input int last, input logic [NR-1:0] pend);
    int c;
    for (int k = 1; k <= NR; k++) begin
      c = (last + k) % NR;
      if (((pend >> c) & NR'(1)) != '0) return c;
    end
    return -1;
  endfunction

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({psel, penable, pwrite, gnt, done, err} !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: psel/penable/pwrite/gnt/done/err=%b required all 0",
               {psel, penable, pwrite, gnt, done, err});
    end
    checks++;
    if (paddr !== '0 || pwdata !== '0 || rdata !== '0) begin
      errors++;
      $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h required 0", paddr, pwdata, rdata);
    end
    tick();
    checks++;
    if (psel !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL idle_no_req: psel=%b gnt=%b required 0 0000", psel, gnt);
    end
  endtask

  task automatic test_single_read();
    per_wait = 0; per_err = 1'b0; per_rdata = 32'hDEADBEEF;
    req_write[0] = 1'b0; req_addr[0] = 32'h8; req[0] = 1'b1;
    tick();
    checks++;
    if (psel !== 1'b1 || penable !== 1'b0 || gnt !== 4'b0001) begin
      errors++;
      $display("FAIL read_setup: psel=%b penable=%b gnt=%b required 1 0 0001", psel, penable, gnt);
    end
    tick();
    checks++;
    if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 32'h8 || pwrite !== 1'b0) begin
      errors++;
      $display("FAIL read_access: psel=%b penable=%b paddr=%h pwrite=%b required 1 1 8 0",
               psel, penable, paddr, pwrite);
    end
    tick();
    checks++;
    if (done !== 4'b0001 || rdata !== 32'hDEADBEEF || err !== 1'b0 || psel !== 1'b0) begin
      errors++;
      $display("FAIL read_done: done=%b rdata=%h err=%b psel=%b required 0001 deadbeef 0 0",
               done, rdata, err, psel);
    end
    tick();
    checks++;
    if (done !== '0 || gnt !== '0 || penable !== 1'b0) begin
      errors++;
      $display("FAIL read_idle: done=%b gnt=%b penable=%b required 0000 0000 0", done, gnt, penable);
    end
  endtask

  task automatic test_rr_order();
    logic [NR-1:0] pats [2];
    logic [NR-1:0] pend, prev;
    logic [IW-1:0] ix;
    int last, got, exp, want;
    apply_reset();
    per_wait = 0; per_err = 1'b0;
    for (int i = 0; i < NR; i++) begin
      ix = IW'(i);
      req_write[ix] = 1'b0;
      req_addr[ix]  = 32'h100 + 32'(16 * i);
    end
    pats[0] = '1;
    pats[1] = 4'b1010;
    last = NR - 1;
    for (int ph = 0; ph < 2; ph++) begin
      for (int w = 0; w < 50 && gnt != '0; w++) tick();
      pend = pats[ph];
      want = $countones(pats[ph]);
      req  = pats[ph];
      prev = '0;
      got  = 0;
      for (int cyc = 0; cyc < 100 && got < want; cyc++) begin
        tick();
        if (prev == '0 && gnt != '0) begin
          exp = rr_pick(last, pend);
          checks++;
          if (oh2idx(gnt) !== exp) begin
            errors++;
            $display("FAIL rr_grant: phase %0d grant idx=%0d required %0d", ph, oh2idx(gnt), exp);
          end
          last = exp;
          pend = pend & ~(NR'(1) << exp);
          got++;
        end
        prev = gnt;
      end
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rr_count: phase %0d grants=%0d required %0d", ph, got, want);
      end
    end
    for (int w = 0; w < 50 && (gnt != '0 || req != '0); w++) tick();
  endtask

  task automatic test_misaligned();
    logic saw_psel;
    saw_psel = 1'b0;
    req_write[2] = 1'b1; req_addr[2] = 32'h6; req_wdata[2] = 32'hA5A5A5A5; req[2] = 1'b1;
    tick();
    if (psel) saw_psel = 1'b1;
    checks++;
    if (done !== 4'b0100 || gnt !== 4'b0100 || err !== 1'b1 || rdata !== '0) begin
      errors++;
      $display("FAIL mis_done: done=%b gnt=%b err=%b rdata=%h required 0100 0100 1 0",
               done, gnt, err, rdata);
    end
    tick();
    if (psel) saw_psel = 1'b1;
    checks++;
    if (done !== '0 || gnt !== '0) begin
      errors++;
      $display("FAIL mis_idle: done=%b gnt=%b required 0000 0000", done, gnt);
    end
    checks++;
    if (saw_psel !== 1'b0) begin
      errors++;
      $display("FAIL mis_psel: psel seen=%b required 0", saw_psel);
    end
  endtask

  task automatic test_timeout();
    int pen;
    logic fin, exp_err;
    logic [DATA_WIDTH-1:0] exp_rd;
    for (int v = 0; v < 2; v++) begin
      per_wait  = (v == 0) ? -1 : TO - 1;
      per_err   = 1'b0;
      per_rdata = 32'h12345678;
      exp_err   = (v == 0);
      exp_rd    = (v == 0) ? '0 : 32'h12345678;
      req_write[1] = 1'b0; req_addr[1] = 32'h40; req[1] = 1'b1;
      pen = 0; fin = 1'b0;
      for (int cyc = 0; cyc < TO + 20 && !fin; cyc++) begin
        tick();
        if (penable) pen++;
        if (done != '0) fin = 1'b1;
      end
      checks++;
      if (!fin || pen !== TO) begin
        errors++;
        $display("FAIL to_penable: variant %0d done_seen=%b penable cycles=%0d required 1 %0d",
                 v, fin, pen, TO);
      end
      checks++;
      if (done !== 4'b0010 || err !== exp_err || rdata !== exp_rd || psel !== 1'b0) begin
        errors++;
        $display("FAIL to_result: variant %0d done=%b err=%b rdata=%h psel=%b required 0010 %b %h 0",
                 v, done, err, rdata, psel, exp_err, exp_rd);
      end
      tick();
    end
  endtask

  task automatic test_slverr();
    logic fin;
    per_wait = 2; per_err = 1'b1; per_rdata = 32'hCAFEF00D;
    req_write[3] = 1'b1; req_addr[3] = 32'h20; req_wdata[3] = 32'h0BADF00D; req[3] = 1'b1;
    fin = 1'b0;
    for (int cyc = 0; cyc < 40 && !fin; cyc++) begin
      tick();
      if (done != '0) fin = 1'b1;
    end
    checks++;
    if (done !== 4'b1000 || err !== 1'b1 || rdata !== '0) begin
      errors++;
      $display("FAIL slverr_done: done=%b err=%b rdata=%h required 1000 1 0", done, err, rdata);
    end
    checks++;
    if (pwrite !== 1'b1 || pwdata !== 32'h0BADF00D || paddr !== 32'h20) begin
      errors++;
      $display("FAIL slverr_cmd: pwrite=%b pwdata=%h paddr=%h required 1 0badf00d 20",
               pwrite, pwdata, paddr);
    end
    tick();
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL slverr_idle: psel=%b penable=%b gnt=%b required 0 0 0000", psel, penable, gnt);
    end
    per_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic reach;
    per_wait = -1; per_err = 1'b0;
    req_write[2] = 1'b0; req_addr[2] = 32'h30; req[2] = 1'b1;
    reach = 1'b0;
    for (int cyc = 0; cyc < 10 && !reach; cyc++) begin
      tick();
      if (penable) reach = 1'b1;
    end
    checks++;
    if (reach !== 1'b1) begin
      errors++;
      $display("FAIL rst_reach: access reached=%b required 1", reach);
    end
    preset = 1'b1;
    tick();
    preset = 1'b0;
    checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || gnt !== '0 || done !== '0) begin
      errors++;
      $display("FAIL rst_abort: psel=%b penable=%b gnt=%b done=%b required 0 0 0000 0000",
               psel, penable, gnt, done);
    end
    per_wait = 0;
    req_write[0] = 1'b0; req_addr[0] = 32'h50; req[0] = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL rst_first: gnt=%b required 0001", gnt);
    end
    for (int w = 0; w < 60 && (req != '0 || gnt != '0); w++) tick();
    checks++;
    if (req !== '0 || gnt !== '0) begin
      errors++;
      $display("FAIL rst_drain: req=%b gnt=%b required 0000 0000", req, gnt);
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] snap, prev_g, bit_i;
    logic [IW-1:0] ix;
    logic [ADDR_WIDTH-1:0] a;
    logic exp_err, mis, tmo;
    logic [DATA_WIDTH-1:0] exp_rd;
    int last_m, owner, g_cyc, exp_off, issued, completed, e, r;
    apply_reset();
    last_m = NR - 1; owner = -1; g_cyc = 0; exp_off = 0;
    exp_err = 1'b0; exp_rd = '0; issued = 0; completed = 0;
    prev_g = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (issued < 60) begin
        for (int i = 0; i < NR; i++) begin
          bit_i = NR'(1) << i;
          if ((req & bit_i) == '0 && (gnt & bit_i) == '0 && $urandom_range(0, 4) == 0) begin
            ix = IW'(i);
            a = 32'($urandom_range(0, 1023)) << 2;
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
            req_write[ix] = 1'($urandom_range(0, 1));
            req_addr[ix]  = a;
            req_wdata[ix] = $urandom();
            req = req | bit_i;
            issued++;
          end
        end
      end
      snap = req;
      tick();
      if (prev_g == '0 && gnt != '0) begin
        e = rr_pick(last_m, snap);
        checks++;
        if (oh2idx(gnt) !== e) begin
          errors++;
          $display("FAIL rnd_grant: cycle %0d grant idx=%0d required %0d", cyc, oh2idx(gnt), e);
        end
        if (e >= 0) begin
          last_m = e; owner = e; g_cyc = cyc;
          ix = IW'(e);
          r = $urandom_range(0, 9);
          per_wait  = (r < 6) ? r % 4 : ((r < 8) ? -1 : TO - 1);
          per_err   = 1'($urandom_range(0, 1));
          per_rdata = $urandom();
          mis = (req_addr[ix][ALIGNBITS-1:0] != '0);
          tmo = !mis && (per_wait < 0);
          exp_off = mis ? 0 : 1 + (tmo ? TO : per_wait + 1);
          exp_err = mis || tmo || per_err;
          exp_rd  = (mis || tmo || req_write[ix]) ? '0 : per_rdata;
          checks++;
          if (paddr !== req_addr[ix] || pwrite !== req_write[ix] || pwdata !== req_wdata[ix]) begin
            errors++;
            $display("FAIL rnd_latch: paddr=%h pwrite=%b pwdata=%h required %h %b %h",
                     paddr, pwrite, pwdata, req_addr[ix], req_write[ix], req_wdata[ix]);
          end
        end
      end
      if (done != '0) begin
        checks++;
        if (owner < 0 || done !== (NR'(1) << owner) || (cyc - g_cyc) !== exp_off ||
            rdata !== exp_rd || err !== exp_err) begin
          errors++;
          $display("FAIL rnd_done: done=%b lat=%0d rdata=%h err=%b required owner %0d lat=%0d rdata=%h err=%b",
                   done, cyc - g_cyc, rdata, err, owner, exp_off, exp_rd, exp_err);
        end
        completed++;
        owner = -1;
      end
      prev_g = gnt;
      if (issued >= 60 && req == '0 && gnt == '0) break;
    end
    checks++;
    if (completed !== issued) begin
      errors++;
      $display("FAIL rnd_count: completed=%0d required %0d", completed, issued);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    per_wait = 0; per_err = 1'b0; per_rdata = '0;
    preset = 1'b1;
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    test_reset();
    test_single_read();
    test_rr_order();
    test_misaligned();
    test_timeout();
    test_slverr();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
